// File: rtl/dlatch_checker.sv
`default_nettype none
// ============================================================================
//  Module   : dlatch_checker
//  Purpose  : Synchronous response checker for a gated D-latch. Samples the
//             latch stimulus (d, en) and response (q, qn), tracks a reference
//             latch model, and compares q/qn against it once {d,en} has been
//             stable for SETTLE cycles. Reports a per-run pass/fail verdict
//             with check and error counters.
//  Ports    : clk, reset         - clock, synchronous active-high reset
//             start              - one-cycle pulse, begins a run when not busy
//             d, en              - stimulus applied to the latch under test
//             q, qn              - latch outputs under observation
//             busy               - run in progress (ARM or CHECK)
//             err                - one-cycle pulse per failed comparison
//             err_count          - failed comparisons this run (saturating)
//             chk_count          - qualified comparisons this run
//             done, fail         - run verdict
//  Revision : 1.0 - initial release
// ============================================================================
module dlatch_checker #(
    parameter int CNT_W        = 8,
    parameter int SETTLE       = 2,
    parameter int N_CHECKS     = 16,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  wire              clk,
    input  wire              reset,
    input  wire              start,
    input  wire              d,
    input  wire              en,
    input  wire              q,
    input  wire              qn,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] chk_count,
    output logic             done,
    output logic             fail
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ARM   = 3'd1;
    localparam logic [2:0] c_ST_CHECK = 3'd2;
    localparam logic [2:0] c_ST_DONE  = 3'd3;
    localparam logic [2:0] c_ST_FAIL  = 3'd4;

    localparam logic [3:0]       c_SETTLE   = 4'(SETTLE);
    localparam logic [CNT_W-1:0] c_LAST_CHK = CNT_W'(N_CHECKS - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    // Registered state
    logic [2:0]       r_state;
    logic             r_d_s;
    logic             r_en_s;
    logic             r_q_s;
    logic             r_qn_s;
    logic [1:0]       r_prev_de;
    logic [3:0]       r_stab;
    logic             r_ref_q;
    logic             r_ref_valid;
    logic [CNT_W-1:0] r_err_count;
    logic [CNT_W-1:0] r_chk_count;
    logic             r_busy;
    logic             r_err;
    logic             r_done;
    logic             r_fail;

    // Next-state values
    logic [2:0]       w_state_nxt;
    logic [3:0]       w_stab_nxt;
    logic             w_ref_q_nxt;
    logic             w_ref_valid_nxt;
    logic [CNT_W-1:0] w_err_count_nxt;
    logic [CNT_W-1:0] w_chk_count_nxt;
    logic             w_err_nxt;
    logic             w_busy_st;
    logic             w_change;
    logic             w_qual;
    logic             w_mismatch;

    always_comb begin
        w_state_nxt     = r_state;
        w_stab_nxt      = r_stab;
        w_ref_q_nxt     = r_ref_q;
        w_ref_valid_nxt = r_ref_valid;
        w_err_count_nxt = r_err_count;
        w_chk_count_nxt = r_chk_count;
        w_err_nxt       = 1'b0;

        w_busy_st  = (r_state == c_ST_ARM) || (r_state == c_ST_CHECK);
        w_change   = ({r_d_s, r_en_s} != r_prev_de);
        // A stimulus change on an otherwise settled cycle disqualifies it:
        // the latch has not yet had time to respond to the new inputs.
        w_qual     = (r_state == c_ST_CHECK) && (r_stab == c_SETTLE) && !w_change;
        w_mismatch = (r_q_s != r_ref_q) || (r_q_s == r_qn_s);

        // Reference latch and stability tracking run only while a run is active.
        if (w_busy_st) begin
            if (w_change) begin
                w_stab_nxt = 4'd0;
            end else if (r_stab != c_SETTLE) begin
                w_stab_nxt = r_stab + 4'd1;
            end
            if (r_en_s) begin
                w_ref_q_nxt     = r_d_s;
                w_ref_valid_nxt = 1'b1;
            end
        end

        case (r_state)
            c_ST_IDLE, c_ST_DONE, c_ST_FAIL: begin
                if (start) begin
                    w_state_nxt     = c_ST_ARM;
                    w_err_count_nxt = '0;
                    w_chk_count_nxt = '0;
                    w_ref_valid_nxt = 1'b0;
                    w_stab_nxt      = 4'd0;
                end
            end
            c_ST_ARM: begin
                if (r_ref_valid) begin
                    w_state_nxt = c_ST_CHECK;
                end
            end
            c_ST_CHECK: begin
                if (w_qual) begin
                    w_chk_count_nxt = r_chk_count + 1'b1;
                    if (w_mismatch) begin
                        w_err_nxt = 1'b1;
                        if (r_err_count != c_CNT_MAX) begin
                            w_err_count_nxt = r_err_count + 1'b1;
                        end
                    end
                    if (w_mismatch && STOP_ON_FAIL) begin
                        w_state_nxt = c_ST_FAIL;
                    end else if (r_chk_count == c_LAST_CHK) begin
                        w_state_nxt = c_ST_DONE;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_d_s       <= 1'b0;
            r_en_s      <= 1'b0;
            r_q_s       <= 1'b0;
            r_qn_s      <= 1'b0;
            r_prev_de   <= 2'b00;
            r_stab      <= 4'd0;
            r_ref_q     <= 1'b0;
            r_ref_valid <= 1'b0;
            r_err_count <= '0;
            r_chk_count <= '0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_d_s       <= d;
            r_en_s      <= en;
            r_q_s       <= q;
            r_qn_s      <= qn;
            r_prev_de   <= {r_d_s, r_en_s};
            r_state     <= w_state_nxt;
            r_stab      <= w_stab_nxt;
            r_ref_q     <= w_ref_q_nxt;
            r_ref_valid <= w_ref_valid_nxt;
            r_err_count <= w_err_count_nxt;
            r_chk_count <= w_chk_count_nxt;
            r_err       <= w_err_nxt;
            // Status outputs are decoded from the next state so they line up
            // with the state register rather than lagging it by a cycle.
            r_busy      <= (w_state_nxt == c_ST_ARM) || (w_state_nxt == c_ST_CHECK);
            r_done      <= (w_state_nxt == c_ST_DONE);
            r_fail      <= (w_state_nxt == c_ST_FAIL) ||
                           ((w_state_nxt == c_ST_DONE) && (w_err_count_nxt != '0));
        end
    end

    assign busy      = r_busy;
    assign err       = r_err;
    assign err_count = r_err_count;
    assign chk_count = r_chk_count;
    assign done      = r_done;
    assign fail      = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_dlatch_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dlatch_checker
//  Purpose  : Self-checking bench for dlatch_checker. Two instances share all
//             inputs: u_dut0 continues past errors, u_dut1 stops on the first.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dlatch_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       d;
    logic       en;
    logic       q;
    logic       qn;
    logic       busy0, err0, done0, fail0;
    logic       busy1, err1, done1, fail1;
    logic [7:0] ec0, cc0, ec1, cc1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dlatch_checker #(
        .CNT_W(8), .SETTLE(2), .N_CHECKS(16), .STOP_ON_FAIL(1'b0)
    ) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .d(d), .en(en), .q(q), .qn(qn),
        .busy(busy0), .err(err0), .err_count(ec0), .chk_count(cc0),
        .done(done0), .fail(fail0)
    );

    dlatch_checker #(
        .CNT_W(8), .SETTLE(2), .N_CHECKS(16), .STOP_ON_FAIL(1'b1)
    ) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .d(d), .en(en), .q(q), .qn(qn),
        .busy(busy1), .err(err1), .err_count(ec1), .chk_count(cc1),
        .done(done1), .fail(fail1)
    );

    typedef struct {
        logic start, d, en, q, qn;
        logic busy, err, done, fail;
        int   ec, cc;
    } vec_t;

    vec_t tbl [22];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all0(input string tag);
        check({tag, "_busy"}, int'(busy0), 0);
        check({tag, "_err"},  int'(err0),  0);
        check({tag, "_done"}, int'(done0), 0);
        check({tag, "_fail"}, int'(fail0), 0);
        check({tag, "_ec"},   int'(ec0),   0);
        check({tag, "_cc"},   int'(cc0),   0);
    endtask

    initial begin
        logic q_lat;
        int   err_seen;

        // Hold and complement checks, then a stimulus that toggles too fast
        // to qualify, then a start that must be ignored mid-run.
        //             st d  en q  qn  busy err done fail ec cc
        tbl[0]  = '{1'b0,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0, 0,0};
        tbl[1]  = '{1'b0,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0, 0,0};
        tbl[2]  = '{1'b1,1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 0,0};
        tbl[3]  = '{1'b0,1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 0,0};
        tbl[4]  = '{1'b0,1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 0,0};
        tbl[5]  = '{1'b0,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 0,1};
        tbl[6]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 0,1};
        tbl[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 0,1};
        tbl[8]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 0,1};
        tbl[9]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 0,1};
        tbl[10] = '{1'b0,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 0,2};
        tbl[11] = '{1'b0,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 0,2};
        tbl[12] = '{1'b0,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 0,2};
        tbl[13] = '{1'b0,1'b1,1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0,1'b0, 0,2};
        tbl[14] = '{1'b0,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0, 1,3};
        tbl[15] = '{1'b0,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 1,4};
        tbl[16] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 1,5};
        tbl[17] = '{1'b0,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 1,5};
        tbl[18] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 1,5};
        tbl[19] = '{1'b0,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 1,5};
        tbl[20] = '{1'b1,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 1,5};
        tbl[21] = '{1'b0,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 1,5};

        // Reset state
        reset = 1'b1; start = 1'b0; d = 1'b1; en = 1'b1; q = 1'b1; qn = 1'b0;
        tick(); tick();
        check_all0("reset");
        reset = 1'b0;

        // Table-driven vectors on the continue-on-error instance
        for (int i = 0; i < 22; i++) begin
            start = tbl[i].start; d = tbl[i].d; en = tbl[i].en;
            q = tbl[i].q; qn = tbl[i].qn;
            tick();
            check($sformatf("vec%0d_busy", i), int'(busy0), int'(tbl[i].busy));
            check($sformatf("vec%0d_err",  i), int'(err0),  int'(tbl[i].err));
            check($sformatf("vec%0d_done", i), int'(done0), int'(tbl[i].done));
            check($sformatf("vec%0d_fail", i), int'(fail0), int'(tbl[i].fail));
            check($sformatf("vec%0d_ec",   i), int'(ec0),   tbl[i].ec);
            check($sformatf("vec%0d_cc",   i), int'(cc0),   tbl[i].cc);
        end
        start = 1'b0;

        // Reset mid-CHECK (chk_count = 5) aborts with all outputs low
        reset = 1'b1;
        tick();
        check_all0("midrun_reset");
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_busy", int'(busy0), 1);
        check("restart_cc",   int'(cc0),   0);
        check("restart_ec",   int'(ec0),   0);

        // Good latch: en toggles every 4 clk, d every 8 clk
        q_lat    = q;
        err_seen = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            en = (((cyc >> 2) & 1) == 0);
            d  = (((cyc >> 3) & 1) == 0);
            if (en) q_lat = d;
            q  = q_lat;
            qn = ~q_lat;
            tick();
            if (err0 || err1) err_seen++;
            if (done0 && done1) break;
        end
        check("good_done0", int'(done0), 1);
        check("good_fail0", int'(fail0), 0);
        check("good_cc0",   int'(cc0),   16);
        check("good_ec0",   int'(ec0),   0);
        check("good_busy0", int'(busy0), 0);
        check("good_done1", int'(done1), 1);
        check("good_fail1", int'(fail1), 0);
        check("good_err_pulses", err_seen, 0);

        // Stuck-at-0 q with d = en = 1
        reset = 1'b1; d = 1'b1; en = 1'b1; q = 1'b0; qn = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("sa0_busy_start", int'(busy0), 1);
        tick(); tick(); tick();
        check("sa0_stop_err",  int'(err1),  1);
        check("sa0_stop_ec",   int'(ec1),   1);
        check("sa0_stop_cc",   int'(cc1),   1);
        check("sa0_stop_fail", int'(fail1), 1);
        check("sa0_stop_done", int'(done1), 0);
        check("sa0_stop_busy", int'(busy1), 0);
        check("sa0_cont_err",  int'(err0),  1);
        check("sa0_cont_ec",   int'(ec0),   1);
        check("sa0_cont_busy", int'(busy0), 1);
        tick();
        check("sa0_stop_err_pulse", int'(err1), 0);
        check("sa0_stop_frozen_cc", int'(cc1),  1);
        check("sa0_stop_frozen_ec", int'(ec1),  1);
        check("sa0_cont_ec2",       int'(ec0),  2);
        for (int i = 0; i < 13; i++) tick();
        check("sa0_cont_cc15",   int'(cc0),   15);
        check("sa0_cont_busy15", int'(busy0), 1);
        check("sa0_cont_done15", int'(done0), 0);
        tick();
        check("sa0_cont_done", int'(done0), 1);
        check("sa0_cont_fail", int'(fail0), 1);
        check("sa0_cont_ec16", int'(ec0),   16);
        check("sa0_cont_cc16", int'(cc0),   16);
        check("sa0_cont_idle", int'(busy0), 0);
        tick();
        check("sa0_done_hold", int'(done0), 1);
        check("sa0_err_end",   int'(err0),  0);
        check("sa0_stop_hold", int'(fail1), 1);

        // Restart from FAIL / DONE
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rerun_busy1", int'(busy1), 1);
        check("rerun_fail1", int'(fail1), 0);
        check("rerun_ec1",   int'(ec1),   0);
        check("rerun_cc1",   int'(cc1),   0);
        check("rerun_done0", int'(done0), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dlatch_checker.md
Name: dlatch_checker

Overview:
- Synchronous response checker for the gated D-latch family in src/memory.
- Observes the latch's data and gate inputs and its q/qn outputs, and keeps an internal reference model.
- Flags mismatches and keeps pass/fail statistics.
- Sits on the observing side of a latch under test, opposite the stimulus driver, so latch benches and on-chip self-test end with a hardware verdict instead of manual waveform reading.

Parameters:
- CNT_W, 8: width of the check and error counters.
- SETTLE, 2: clock cycles {d,en} must be stable before q/qn are compared (1..15).
- N_CHECKS, 16: number of qualified comparisons in one run.
- STOP_ON_FAIL, 0: 1 = the first error ends the run in FAIL; 0 = count errors and continue.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle pulse that begins a run. Accepted in IDLE, DONE and FAIL.
- d, input, 1: data input applied to the latch under test.
- en, input, 1: gate input applied to the latch under test (transparent when 1).
- q, input, 1: latch output.
- qn, input, 1: latch complementary output.
- busy, output, 1: high in ARM and CHECK.
- err, output, 1: one-cycle pulse on each failed comparison.
- err_count, output, CNT_W: failed comparisons in the current run; saturates at all-ones.
- chk_count, output, CNT_W: qualified comparisons performed in the current run.
- done, output, 1: high in DONE. Held until start or reset.
- fail, output, 1: high in FAIL, or in DONE when err_count != 0.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE.
  - busy = err = done = fail = 0.
  - err_count = chk_count = 0.
  - Internal ref_q = 0, ref_valid = 0, stab_cnt = 0, previous-sample register = 0.
  - Reset asserted mid-run aborts the run immediately, with no done/fail report.
- Input sampling: d, en, q and qn are registered once per clk (one-cycle sample latency). All logic below acts on the registered copies.
- Reference model, updated every cycle in ARM/CHECK:
  - Sampled en = 1: ref_q <= sampled d, ref_valid <= 1.
  - Sampled en = 0: ref_q holds.
- Stability counter:
  - Cleared to 0 when sampled {d,en} differs from the previous sample, and on entry to ARM.
  - Otherwise increments, saturating at SETTLE.
- FSM:
  - IDLE: start -> ARM, clearing counters and ref_valid.
  - ARM: waits for ref_valid = 1 (first transparent sample), then -> CHECK. No comparisons are made in ARM.
  - CHECK: a comparison is qualified on any cycle with stab_cnt == SETTLE.
    - On each qualified cycle: chk_count += 1.
    - Error condition: (q != ref_q) or (q == qn).
    - On error: err pulses next cycle and err_count += 1 (saturating).
    - Error with STOP_ON_FAIL = 1 -> FAIL.
    - Otherwise, when chk_count reaches N_CHECKS -> DONE. The last comparison is counted before the transition.
  - DONE: done = 1; fail = (err_count != 0). start -> ARM (new run, counters cleared).
  - FAIL: fail = 1, done = 0, counters frozen. start -> ARM.
- start while busy is ignored.
- A stimulus change on a qualified cycle is not compared on that cycle; stab_cnt restarts.
- The complement check (q == qn) is evaluated only on qualified cycles. This tolerates the latch's transient glitches.
- Counters stay frozen outside ARM/CHECK.

Test Plan:
1. Good latch model, en toggling every 4 clk, d toggling every 8 clk, SETTLE = 2, N_CHECKS = 16, start pulse -> busy = 1, ARM exits after the first en = 1 sample, chk_count reaches 16, done = 1, fail = 0, err_count = 0, err never pulses.
2. Hold check: en = 1 with d = 1, then en = 0 and d toggles 1->0->1 -> ref_q stays 1, and q = 1 produces no error on the qualified cycles.
3. Stuck-at-0 q with d = 1, en = 1, STOP_ON_FAIL = 1 -> first qualified cycle pulses err, err_count = 1, state FAIL, fail = 1, done = 0, chk_count = 1.
4. Same fault with STOP_ON_FAIL = 0, N_CHECKS = 16 -> err pulses on every qualified mismatch, run ends with done = 1, fail = 1, err_count equal to the number of d = 1 checks.
5. q = qn = 1 while ref_q = 1 -> complement error counted. Also: d toggling every cycle -> chk_count stays 0 and busy stays 1.
6. reset asserted during CHECK with chk_count = 5 -> next cycle IDLE, all outputs 0. A following start restarts from ARM with counters 0. A start pulse during CHECK is ignored.
